// File: rtl/sysid_boot_checker.sv
// Avalon-MM read master that fetches the system ID and build timestamp words and checks them.
// Optional per-transaction timeout is built when SYSID_CHECK_TIMEOUT_EN is defined.
module sysid_boot_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd960051513,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1434268948,
  parameter bit          AUTO_START         = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES     = 255
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  status,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_ID,
    S_WAIT_ID,
    S_RD_TS,
    S_WAIT_TS,
    S_CHECK,
    S_DONE
  } state_t;

  state_t      state_q;
  logic        autoDone_q;
  logic        avmAddress_q;
  logic        avmRead_q;
  logic        busy_q;
  logic        done_q;
  logic        pass_q;
  logic [1:0]  status_q;
  logic        timeout_q;
  logic [31:0] idValue_q;
  logic [31:0] tsValue_q;

  logic accept;
  logic expired;

  assign accept = avmRead_q && !avm_waitrequest;

`ifdef SYSID_CHECK_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] txnCnt_q;

  assign expired = (txnCnt_q == CNT_W'(TIMEOUT_CYCLES));

  // Counts cycles of the current transaction; zero outside RD/WAIT and on the hop into RD_TS.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      txnCnt_q <= '0;
    end else begin
      case (state_q)
        S_RD_ID, S_RD_TS, S_WAIT_TS: txnCnt_q <= txnCnt_q + CNT_W'(1);
        S_WAIT_ID: begin
          if (avm_readdatavalid) txnCnt_q <= '0;
          else                   txnCnt_q <= txnCnt_q + CNT_W'(1);
        end
        default: txnCnt_q <= '0;
      endcase
    end
  end
`else
  assign expired = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      autoDone_q   <= 1'b0;
      avmAddress_q <= 1'b0;
      avmRead_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_q       <= 1'b0;
      status_q     <= 2'b00;
      timeout_q    <= 1'b0;
      idValue_q    <= '0;
      tsValue_q    <= '0;
    end else begin
      autoDone_q <= 1'b1;
      case (state_q)
        S_IDLE: begin
          if (start || (AUTO_START && !autoDone_q)) begin
            state_q      <= S_RD_ID;
            avmRead_q    <= 1'b1;
            avmAddress_q <= 1'b0;
            busy_q       <= 1'b1;
          end
        end
        S_RD_ID, S_RD_TS: begin
          if (expired) begin
            state_q   <= S_DONE;
            avmRead_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            status_q  <= 2'b00;
            timeout_q <= 1'b1;
          end else if (accept) begin
            avmRead_q <= 1'b0;
            state_q   <= (state_q == S_RD_ID) ? S_WAIT_ID : S_WAIT_TS;
          end
        end
        // A response landing on the expiry cycle still counts as a completed read.
        S_WAIT_ID: begin
          if (avm_readdatavalid) begin
            idValue_q    <= avm_readdata;
            state_q      <= S_RD_TS;
            avmRead_q    <= 1'b1;
            avmAddress_q <= 1'b1;
          end else if (expired) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            status_q  <= 2'b00;
            timeout_q <= 1'b1;
          end
        end
        S_WAIT_TS: begin
          if (avm_readdatavalid) begin
            tsValue_q <= avm_readdata;
            state_q   <= S_CHECK;
          end else if (expired) begin
            state_q   <= S_DONE;
            busy_q    <= 1'b0;
            done_q    <= 1'b1;
            pass_q    <= 1'b0;
            status_q  <= 2'b00;
            timeout_q <= 1'b1;
          end
        end
        // An ID mismatch outranks a timestamp mismatch.
        S_CHECK: begin
          state_q <= S_DONE;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
          if (idValue_q != EXPECTED_ID) begin
            status_q <= 2'b10;
            pass_q   <= 1'b0;
          end else if (tsValue_q != EXPECTED_TIMESTAMP) begin
            status_q <= 2'b11;
            pass_q   <= 1'b0;
          end else begin
            status_q <= 2'b01;
            pass_q   <= 1'b1;
          end
        end
        S_DONE: begin
          if (start) begin
            state_q      <= S_RD_ID;
            avmRead_q    <= 1'b1;
            avmAddress_q <= 1'b0;
            busy_q       <= 1'b1;
            done_q       <= 1'b0;
            pass_q       <= 1'b0;
            status_q     <= 2'b00;
            timeout_q    <= 1'b0;
          end
        end
        default: begin
          state_q   <= S_IDLE;
          avmRead_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign avm_address = avmAddress_q;
  assign avm_read    = avmRead_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign status      = status_q;
  assign timeout     = timeout_q;
  assign id_value    = idValue_q;
  assign ts_value    = tsValue_q;

endmodule

// File: tb/tb_sysid_boot_checker.sv
// Randomized bench for sysid_boot_checker: a small Avalon slave plus a word-level reference model.
// Timeout expectations follow SYSID_CHECK_TIMEOUT_EN when the bench is built with it.
module tb_sysid_boot_checker;

  localparam logic [31:0] EXP_ID = 32'd960051513;
  localparam logic [31:0] EXP_TS = 32'd1434268948;
  localparam int          TO     = 16;

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        avm_address;
  logic        avm_read;
  logic        avm_waitrequest;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        busy;
  logic        done;
  logic        pass;
  logic [1:0]  status;
  logic        timeout;
  logic [31:0] id_value;
  logic [31:0] ts_value;

  int checkCount = 0;
  int failCount  = 0;

  logic [31:0] slaveId;
  logic [31:0] slaveTs;
  int          waitCycles;
  bit          respondEn;
  bit          strayEn;
  int          acceptCount;
  bit [1:0]    acceptAddrs;
  logic [31:0] lastId;
  logic [31:0] lastTs;

  sysid_boot_checker #(
    .EXPECTED_ID       (EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .AUTO_START        (1'b1),
    .TIMEOUT_CYCLES    (TO)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .start            (start),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_waitrequest  (avm_waitrequest),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .status           (status),
    .timeout          (timeout),
    .id_value         (id_value),
    .ts_value         (ts_value)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic logic [1:0] modelStatus(input logic [31:0] idW, input logic [31:0] tsW);
    if (idW != EXP_ID) return 2'b10;
    if (tsW != EXP_TS) return 2'b11;
    return 2'b01;
  endfunction

  // Slave: stalls each request waitCycles cycles, answers one cycle after acceptance, optionally injects stray valids.
  initial begin
    logic prevRead, prevWait, prevAddr, acceptedPrev, acceptedAddr;
    int   waitLeft;
    prevRead = 0; prevWait = 0; prevAddr = 0; acceptedPrev = 0; acceptedAddr = 0; waitLeft = 0;
    avm_waitrequest = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata = '0;
    forever begin
      @(posedge clock);
      #1;
      if (reset_n && prevRead && prevWait) begin
        checkOutput("read_held", avm_read, 1'b1);
        checkOutput("addr_held", avm_address, prevAddr);
      end
      avm_readdatavalid = 1'b0;
      avm_readdata = $urandom;
      if (acceptedPrev && respondEn) begin
        avm_readdatavalid = 1'b1;
        avm_readdata = acceptedAddr ? slaveTs : slaveId;
      end else if (strayEn && (avm_read || !busy) && $urandom_range(0, 3) == 0) begin
        avm_readdatavalid = 1'b1;
      end
      if (avm_read) begin
        if (waitLeft > 0) begin
          avm_waitrequest = 1'b1;
          waitLeft--;
        end else begin
          avm_waitrequest = 1'b0;
        end
      end else begin
        avm_waitrequest = 1'b0;
        waitLeft = waitCycles;
      end
      prevRead = avm_read;
      prevWait = avm_waitrequest;
      prevAddr = avm_address;
      acceptedPrev = avm_read && !avm_waitrequest && reset_n;
      if (acceptedPrev) begin
        acceptedAddr = avm_address;
        if (acceptCount < 2) acceptAddrs[acceptCount] = avm_address;
        acceptCount++;
      end
    end
  end

  // One full check: launch (reset release or start pulse), verify timing, then results against the model.
  task automatic applyStimulus(input logic [31:0] idW, input logic [31:0] tsW, input int waitC,
                               input bit fromReset, input bit busyStart, input bit stray);
    int latency;
    slaveId = idW;
    slaveTs = tsW;
    waitCycles = waitC;
    strayEn = stray;
    respondEn = 1'b1;
    acceptCount = 0;
    acceptAddrs = 2'b00;
    latency = 5 + 2 * waitC;
    if (fromReset) begin
      @(negedge clock) reset_n = 1'b1;
      @(negedge clock);
    end else begin
      @(negedge clock) start = 1'b1;
      @(negedge clock) start = 1'b0;
    end
    checkOutput("launch_ctrl", {busy, done, pass, status, timeout}, {1'b1, 5'b0});
    checkOutput("launch_id_kept", id_value, lastId);
    checkOutput("launch_ts_kept", ts_value, lastTs);
    for (int i = 1; i < latency; i++) begin
      @(negedge clock);
      if (busyStart && i == 2) start = 1'b1;
      if (busyStart && i == 3) start = 1'b0;
      if (i == latency - 1) checkOutput("pre_done", {busy, done}, 2'b10);
    end
    @(negedge clock);
    checkOutput("done_busy", {busy, done, timeout}, 3'b010);
    checkOutput("status", status, modelStatus(idW, tsW));
    checkOutput("pass", pass, modelStatus(idW, tsW) == 2'b01);
    checkOutput("id_value", id_value, idW);
    checkOutput("ts_value", ts_value, tsW);
    checkOutput("accept_count", acceptCount, 2);
    checkOutput("accept_addrs", acceptAddrs, 2'b10);
    lastId = idW;
    lastTs = tsW;
  endtask

  initial begin
    reset_n = 1'b0;
    start = 1'b0;
    slaveId = EXP_ID;
    slaveTs = EXP_TS;
    waitCycles = 0;
    respondEn = 1'b1;
    strayEn = 1'b0;
    acceptCount = 0;
    acceptAddrs = 2'b00;
    lastId = '0;
    lastTs = '0;
    repeat (3) @(negedge clock);
    checkOutput("reset_ctrl", {avm_read, avm_address, busy, done, pass, status, timeout}, 8'h00);
    checkOutput("reset_id", id_value, 32'h0);
    checkOutput("reset_ts", ts_value, 32'h0);

    applyStimulus(EXP_ID, EXP_TS, 0, 1'b1, 1'b0, 1'b0);
    applyStimulus(32'h12345678, EXP_TS, 0, 1'b0, 1'b0, 1'b0);
    applyStimulus(EXP_ID, EXP_TS, 5, 1'b0, 1'b0, 1'b0);
    applyStimulus(EXP_ID, 32'h0000DEAD, 0, 1'b0, 1'b1, 1'b0);
    applyStimulus(EXP_ID, EXP_TS, 0, 1'b0, 1'b0, 1'b1);

    // Abort a run in WAIT_TS with an asynchronous reset, then let auto-start re-run it.
    slaveId = 32'hCAFEF00D;
    slaveTs = EXP_TS;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    repeat (3) @(negedge clock);
    #1 reset_n = 1'b0;
    #1;
    checkOutput("async_reset_ctrl", {avm_read, avm_address, busy, done, pass, status, timeout}, 8'h00);
    checkOutput("async_reset_id", id_value, 32'h0);
    checkOutput("async_reset_ts", ts_value, 32'h0);
    lastId = '0;
    lastTs = '0;
    @(negedge clock);
    applyStimulus(EXP_ID, EXP_TS, 0, 1'b1, 1'b0, 1'b0);

    for (int r = 0; r < 10; r++) begin
      logic [31:0] idW, tsW;
      idW = ($urandom_range(0, 2) == 0) ? $urandom : EXP_ID;
      tsW = ($urandom_range(0, 2) == 0) ? $urandom : EXP_TS;
      applyStimulus(idW, tsW, $urandom_range(0, 4), 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Slave never answers: bounded abort with the timeout build, endless wait without it.
    respondEn = 1'b0;
    strayEn = 1'b0;
    waitCycles = 0;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
`ifdef SYSID_CHECK_TIMEOUT_EN
    for (int i = 1; i < TO + 1; i++) begin
      @(negedge clock);
      if (i == TO) checkOutput("pre_timeout", {busy, done, timeout}, 3'b100);
    end
    @(negedge clock);
    checkOutput("timeout_ctrl", {busy, done, timeout, pass, avm_read}, 5'b01100);
    checkOutput("timeout_status", status, 2'b00);
`else
    repeat (300) @(negedge clock);
    checkOutput("no_timeout_busy", {busy, done, timeout, pass}, 4'b1000);
    checkOutput("no_timeout_status", status, 2'b00);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
